// File: rtl/id_ex_ctrl_reg_pkg.sv
// id_ex_ctrl_reg_pkg: shared decode/execute control types and the bubble constant
package id_ex_ctrl_reg_pkg;
  typedef enum logic [2:0] {
    ALU_CONTROL_ADD = 3'd0,
    ALU_CONTROL_SUB,
    ALU_CONTROL_RTYPE,
    ALU_CONTROL_ITYPE,
    ALU_CONTROL_BRANCH
  } alu_control_t;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  typedef struct packed {
    logic         reg_write;
    logic         mem_write;
    logic         alu_src_a;
    logic         alu_src_b;
    logic [1:0]   result_src;
    logic         branch;
    logic         jump;
    alu_control_t alu_control;
  } id_ex_ctrl_t;
  // Matches the decoder's default outputs, so a bubble executes as a NOP
  localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
    reg_write:   1'b0,
    mem_write:   1'b0,
    alu_src_a:   1'b1,
    alu_src_b:   1'b0,
    result_src:  2'b00,
    branch:      1'b0,
    jump:        1'b0,
    alu_control: ALU_CONTROL_ADD
  };
endpackage

// File: rtl/id_ex_ctrl_reg_hazard_detect.sv
// hazard_detect: combinational load-use detection and stall/flush generation
module hazard_detect
  import id_ex_ctrl_reg_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            valid_d,
  input  logic            valid_e,
  input  logic [1:0]      result_src_e,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rd_e,
  input  logic            pc_src_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e
);
  logic lw_hz;
  // rs2 is compared even when unused; the rare spurious stall is accepted
  always_comb begin
    lw_hz   = valid_d & valid_e & (result_src_e == RESULT_SRC_LOAD) & (rd_e != '0) &
              ((rs1_d == rd_e) | (rs2_d == rd_e));
    stall_f = lw_hz & ~pc_src_e;
    stall_d = lw_hz & ~pc_src_e;
    flush_d = pc_src_e;
    flush_e = lw_hz | pc_src_e;
  end
endmodule

// File: rtl/id_ex_ctrl_reg.sv
// id_ex_ctrl_reg: ID/EX control pipeline register with hazard control and event counters
module id_ex_ctrl_reg
  import id_ex_ctrl_reg_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic             alu_src_a_d,
  input  logic             alu_src_b_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic [1:0]       result_src_d,
  input  alu_control_t     alu_control_d,
  input  logic [2:0]       funct3_d,
  input  logic             funct7b5_d,
  input  logic [RA_W-1:0]  rs1_d,
  input  logic [RA_W-1:0]  rs2_d,
  input  logic [RA_W-1:0]  rd_d,
  input  logic             pc_src_e,
  output logic             valid_e,
  output id_ex_ctrl_t      ctrl_e,
  output logic [2:0]       funct3_e,
  output logic             funct7b5_e,
  output logic [RA_W-1:0]  rs1_e,
  output logic [RA_W-1:0]  rs2_e,
  output logic [RA_W-1:0]  rd_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  id_ex_ctrl_t ctrl_d;
  always_comb ctrl_d = '{
    reg_write:   reg_write_d,
    mem_write:   mem_write_d,
    alu_src_a:   alu_src_a_d,
    alu_src_b:   alu_src_b_d,
    result_src:  result_src_d,
    branch:      branch_d,
    jump:        jump_d,
    alu_control: alu_control_d
  };
  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .valid_d      (valid_d),
    .valid_e      (valid_e),
    .result_src_e (ctrl_e.result_src),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_e         (rd_e),
    .pc_src_e     (pc_src_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e)
  );
  // A stalled D instruction re-presents next cycle, so E always takes a bubble rather than freezing
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_e    <= 1'b0;
      ctrl_e     <= ID_EX_BUBBLE;
      funct3_e   <= '0;
      funct7b5_e <= 1'b0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
    end else begin
      valid_e    <= valid_d;
      ctrl_e     <= ctrl_d;
      funct3_e   <= funct3_d;
      funct7b5_e <= funct7b5_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
    end
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (pc_src_e && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: doc/id_ex_ctrl_reg.md
Name: id_ex_ctrl_reg

Overview:
- Decode-to-execute control pipeline register for the pipelined RV32I core.
- Captures the main decoder's control bundle and the register specifiers in D, and presents them registered to E.
- Contains the load-use hazard detector and generates the stall/flush controls for the F, D and E stages.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 32, width of the stall/flush event counters.
- RA_W, 5, register-file address width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- valid_d  in  1  D-stage holds a real instruction
- reg_write_d, mem_write_d, alu_src_a_d, alu_src_b_d, branch_d, jump_d  in  1 each  decoder controls
- result_src_d  in  2  decoder result select (01 = load)
- alu_control_d  in  alu_control_t  decoder ALU class
- funct3_d  in  3  instruction funct3
- funct7b5_d  in  1  instruction bit 30
- rs1_d, rs2_d, rd_d  in  RA_W each  register specifiers
- pc_src_e  in  1  E-stage redirect (branch taken or jump)
- valid_e  out  1  registered valid
- ctrl_e  out  id_ex_ctrl_t  registered control bundle (all *_d controls above)
- funct3_e  out  3  registered funct3
- funct7b5_e  out  1  registered bit 30
- rs1_e, rs2_e, rd_e  out  RA_W each  registered specifiers
- stall_f, stall_d  out  1  hold PC and the IF/ID register
- flush_d, flush_e  out  1  bubble IF/ID and ID/EX
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Load-use detect is combinational: lw_hz = valid_d & valid_e & ctrl_e.result_src==2'b01 & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e).
- rs2 is compared even for I-type/load instructions. The resulting occasional spurious stall is accepted.
- stall_f = stall_d = lw_hz & ~pc_src_e. A redirect overrides a stall.
- flush_d = pc_src_e.
- flush_e = lw_hz | pc_src_e.
- The hazard outputs are purely combinational with zero latency, so they are valid in the same cycle as their inputs.
- The ID/EX register updates on the rising edge of clk, with this priority:
  1. reset: load a bubble into the register; clear both counters.
  2. flush_e: load a bubble into the register.
  3. Otherwise: capture all *_d inputs into the *_e outputs. valid_e takes valid_d.
- Bubble value:
  - valid_e=0.
  - reg_write, mem_write, branch and jump all 0.
  - alu_src_a=1, alu_src_b=0, result_src=00.
  - alu_control=ALU_CONTROL_ADD.
  - funct3/funct7b5=0.
  - rs1_e/rs2_e/rd_e=0.
  - The bubble matches the decoder's default outputs, so it is architecturally a NOP.
- Reset values: every registered output holds the bubble value, and both counters are 0.
- stall_d is never used to freeze this register. A stalled D instruction re-presents next cycle while E receives a bubble.
- Latency: exactly 1 cycle from D inputs to E outputs.
- stall_cnt increments by 1 on every clock where stall_d=1.
- flush_cnt increments by 1 on every clock where pc_src_e=1.
- Both counters saturate at all-ones and never wrap.
- reset asserted mid-stall or mid-flush wins unconditionally. The cycle after reset deasserts produces no stall or flush, because valid_e=0.
- Simultaneous lw_hz and pc_src_e:
  - stall_f=stall_d=0, flush_d=1, flush_e=1.
  - stall_cnt does not increment; flush_cnt increments.
- valid_d=0 never raises a hazard, and a bubble in E (valid_e=0) never raises a hazard.

Decomposition:
- types package:
  - add the struct id_ex_ctrl_t {reg_write, mem_write, alu_src_a, alu_src_b, result_src[1:0], branch, jump, alu_control}.
  - add the constant RESULT_SRC_LOAD=2'b01.
  - add the constant ID_EX_BUBBLE as the bubble value of id_ex_ctrl_t.
  - alu_control_t is reused as already defined there.
- One sub-module, hazard_detect: purely combinational lw_hz and the stall/flush equations.
- The register and counters stay in the parent.

Test Plan:
- Reset: hold reset for 2 cycles with random D inputs. Required: valid_e=0, ctrl_e==ID_EX_BUBBLE, counters 0, all stall/flush outputs 0.
- Pass-through: R-type in D (reg_write_d=1, alu_control=ALU_CONTROL_RTYPE, rd_d=5, valid_d=1). Required: these values appear on the E outputs one cycle later; stall/flush outputs 0.
- Load-use: load with rd=7 in E, then add with rs2_d=7 in D. Required: stall_f=stall_d=flush_e=1 for exactly one cycle, then a bubble in E, then the add in E on the following cycle; stall_cnt=1.
- x0 / no dependency: load with rd=0, then D uses rs1=0. Required: no stall. Load with rd=3, then D uses rs1=4/rs2=5. Required: no stall.
- Redirect: pc_src_e=1 for 1 cycle. Required: flush_d=flush_e=1, E takes a bubble, flush_cnt=1. If lw_hz coincides: stall outputs 0 and stall_cnt unchanged.
- Saturation: force stall_cnt to all-ones via CNT_W=4 and 20 consecutive load-use stalls. Required: stall_cnt holds at 4'hF. Then assert reset mid-stall. Required: counters go to 0 and E holds a bubble on the next edge.
